// File: rtl/reg_writeback.sv
// reg_writeback: register-file writeback arbiter.
// Merges single-cycle ALU results and buffered load responses into the
// register file's single write port. The ALU always has priority, and load
// responses wait in a circular FIFO of LD_DEPTH entries.
// Optional feature macro: REG_WB_SCOREBOARD_EN adds the pending-load
// scoreboard (busy) and the ALU-versus-pending-load hazard pulse. When it is
// undefined, busy and hazard_err are tied to 0 and issue_* are ignored.
module reg_writeback #(
    parameter int LD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        reg_we,
    output logic        hazard_err
);

    localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t        fifo_mem [LD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             enq;
    logic             deq;
    logic             sel_valid;
    wb_entry_t        sel;

    assign fifo_full  = (count == CNT_W'(LD_DEPTH));
    assign fifo_empty = (count == '0);
    // Ready depends only on occupancy and run, never on ld_valid.
    assign ld_ready   = run && !fifo_full;
    assign enq        = ld_valid && ld_ready;
    // A load drains only in a running cycle with no ALU result to write.
    assign deq        = run && !alu_valid && !fifo_empty;

    // FIFO storage: the write side captures accepted load responses.
    // NOTE: storage has no reset; count and pointers alone define which
    // entries are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= '{rd: ld_rd, data: ld_data};
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally at a power-of-two depth.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Arbitration: the ALU wins, and otherwise the FIFO head is selected when present.
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        if (run) begin
            if (alu_valid) begin
                sel_valid = 1'b1;
                sel       = '{rd: alu_rd, data: alu_data};
            end else if (!fifo_empty) begin
                sel_valid = 1'b1;
                sel       = fifo_mem[rd_ptr];
            end
        end
    end

    // Registered write port: x0 targets are consumed without raising reg_we.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_we <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else if (run) begin
            reg_we <= sel_valid && (sel.rd != 5'd0);
            if (sel_valid && (sel.rd != 5'd0)) begin
                waddr <= sel.rd;
                wdata <= sel.data;
            end
        end else begin
            reg_we <= 1'b0;
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_set;
    logic [31:0] busy_clr;
    logic        hazard_q;

    // Scoreboard update masks. Bit 0 is never touched, so it stays 0 from reset.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (run && issue_valid && (issue_rd != 5'd0)) busy_set[issue_rd] = 1'b1;
        if (deq && (sel.rd != 5'd0))                  busy_clr[sel.rd]   = 1'b1;
    end

    // Scoreboard and hazard registers. A set overrides a clear of the same register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            hazard_q <= 1'b0;
        end else begin
            if (run) busy_q <= (busy_q & ~busy_clr) | busy_set;
            hazard_q <= run && alu_valid && (alu_rd != 5'd0) && busy_q[alu_rd];
        end
    end

    assign busy       = busy_q;
    assign hazard_err = hazard_q;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_rd};
    assign busy         = '0;
    assign hazard_err   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: self-checking bench for reg_writeback.
// A queue-based reference model predicts every output cycle by cycle.
// Directed scenarios add literal expectations, and a randomized phase follows.
module tb_reg_writeback;

    localparam int LD_DEPTH = 4;
`ifdef REG_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        reg_we;
    logic        hazard_err;

    int checks = 0;
    int errors = 0;

    reg_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .waddr       (waddr),
        .wdata       (wdata),
        .reg_we      (reg_we),
        .hazard_err  (hazard_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending responses and a busy array.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_busy = '0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_haz  = 1'b0;
    ent_t        m_sel;
    bit          m_have;
    bit          m_take;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_q.delete();
            m_busy  = '0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_haz   = 1'b0;
        end else if (!run) begin
            m_we  = 1'b0;
            m_haz = 1'b0;
        end else begin
            m_take = (m_q.size() < LD_DEPTH);
            m_have = 1'b0;
            m_haz  = 1'b0;
            if (alu_valid) begin
                m_sel.rd   = alu_rd;
                m_sel.data = alu_data;
                m_have     = 1'b1;
                m_haz      = SB && (alu_rd != 5'd0) && m_busy[alu_rd];
            end else if (m_q.size() > 0) begin
                m_sel  = m_q.pop_front();
                m_have = 1'b1;
                if (m_sel.rd != 5'd0) m_busy[m_sel.rd] = 1'b0;
            end
            if (SB && issue_valid && (issue_rd != 5'd0)) m_busy[issue_rd] = 1'b1;
            m_we = m_have && (m_sel.rd != 5'd0);
            if (m_we) begin
                m_waddr = m_sel.rd;
                m_wdata = m_sel.data;
            end
            if (m_take && ld_valid) m_q.push_back('{rd: ld_rd, data: ld_data});
        end
        #1;
        if (reset_n) begin
            check("m_reg_we", 32'(reg_we), 32'(m_we));
            if (m_we) begin
                check("m_waddr", 32'(waddr), 32'(m_waddr));
                check("m_wdata", wdata, m_wdata);
            end
            check("m_busy", busy, m_busy);
            check("m_hazard", 32'(hazard_err), 32'(m_haz));
            check("m_ld_ready", 32'(ld_ready), 32'(run && (m_q.size() < LD_DEPTH)));
        end
    end

    task automatic idle();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        check("rst_reg_we", 32'(reg_we), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_hazard", 32'(hazard_err), 0);
        check("rst_ld_ready", 32'(ld_ready), 1);
        reset_n = 1'b1;

        // Single ALU write.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        idle();
        check("alu_we", 32'(reg_we), 1);
        check("alu_waddr", 32'(waddr), 5);
        check("alu_wdata", wdata, 32'hDEADBEEF);
        @(negedge clk);
        check("alu_we_drop", 32'(reg_we), 0);

        // Fill the FIFO under continuous ALU traffic, then drain it.
        alu_valid = 1'b1; alu_rd = 5'd9;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("fill_ready_low", 32'(ld_ready), 0);
            ld_valid = 1'b1; ld_rd = 5'(i + 1); ld_data = 32'h100 + i; alu_data = i;
            @(negedge clk);
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_we", 32'(reg_we), 1);
            check("drain_waddr", 32'(waddr), 32'(i + 1));
            check("drain_wdata", wdata, 32'h100 + i);
        end
        check("drain_ready_back", 32'(ld_ready), 1);

        // Writes to x0 are consumed without enabling the write port.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h300 + i;
            @(negedge clk);
            check("x0_alu_we", 32'(reg_we), 0);
        end
        check("x0_full", 32'(ld_ready), 0);
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("x0_load_we", 32'(reg_we), 0);
            check("x0_busy0", 32'(busy[0]), 0);
        end
        check("x0_consumed", 32'(ld_ready), 1);

        // Scoreboard set, hazard pulse, and clear on load writeback.
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        idle();
        check("sb_busy7_set", 32'(busy[7]), 32'(SB));
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA5A5;
        @(negedge clk);
        idle();
        check("hz_we", 32'(reg_we), 1);
        check("hz_waddr", 32'(waddr), 7);
        check("hz_pulse", 32'(hazard_err), 32'(SB));
        @(negedge clk);
        check("hz_pulse_end", 32'(hazard_err), 0);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12;
        @(negedge clk);
        idle();
        check("sb_busy7_queued", 32'(busy[7]), 32'(SB));
        @(negedge clk);
        check("sb_ld_we", 32'(reg_we), 1);
        check("sb_ld_waddr", 32'(waddr), 7);
        check("sb_ld_wdata", wdata, 32'h12);
        check("sb_busy7_clr", 32'(busy[7]), 0);

        // Freeze with two entries queued, resume, then reset mid-drain.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h200;
        @(negedge clk);
        ld_rd = 5'd11; ld_data = 32'h201;
        @(negedge clk);
        idle();
        run = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_we", 32'(reg_we), 0);
            check("frz_ready", 32'(ld_ready), 0);
            check("frz_busy", busy, 0);
        end
        idle();
        run = 1'b1;
        @(negedge clk);
        check("resume_we", 32'(reg_we), 1);
        check("resume_waddr", 32'(waddr), 10);
        check("resume_wdata", wdata, 32'h200);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_we", 32'(reg_we), 0);
        check("arst_waddr", 32'(waddr), 0);
        check("arst_wdata", wdata, 0);
        check("arst_busy", busy, 0);
        check("arst_hazard", 32'(hazard_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        check("arst_ready", 32'(ld_ready), 1);
        @(negedge clk);
        check("arst_no_drain", 32'(reg_we), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            run         = ($urandom_range(0, 9) != 0);
            alu_valid   = ($urandom_range(0, 9) < 4);
            alu_rd      = 5'($urandom);
            alu_data    = $urandom;
            ld_valid    = 1'($urandom_range(0, 1));
            ld_rd       = 5'($urandom);
            ld_data     = $urandom;
            issue_rd    = 5'($urandom);
            issue_valid = ($urandom_range(0, 3) == 0) && !m_busy[issue_rd];
            @(negedge clk);
        end
        idle();
        run = 1'b1;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
